// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and multiply/divide interlocks, branch flush,
// MD-unit sequencing. Optional performance counters under `HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT = 32
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  pcsource,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_use_rs,
  input  logic        d_use_rt,
  input  logic        d_md,
  input  logic        d_hilo,
  input  logic        e_wreg,
  input  logic        e_m2reg,
  input  logic [4:0]  e_rn,
  output logic        wpc,
  output logic        wir,
  output logic        flush_ir,
  output logic        bubble,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    MDBUSY = 1'b1
  } state_e;

  localparam logic [5:0] CNT_LOAD = 6'(MD_LAT - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       lu, mh, stall;

  always_comb begin
    lu = e_wreg & e_m2reg & (e_rn != '0) &
         ((d_use_rs & (d_rs == e_rn)) | (d_use_rt & (d_rt == e_rn)));
    mh    = (state_q == MDBUSY) & (d_md | d_hilo);
    stall = lu | mh;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (md_start) begin
          state_d = MDBUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MDBUSY: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 6'd1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // A stall (load-use or MD) suppresses the flush so the branch re-resolves after release.
  always_comb begin
    wpc      = ~stall;
    wir      = ~stall;
    bubble   = stall;
    flush_ir = (pcsource != '0) & ~stall;
    md_start = (state_q == RUN) & d_md & ~lu;
    md_busy  = (state_q == MDBUSY);
    md_done  = md_busy & (cnt_q == '0);
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_ir)                     flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_LAT=32); counter expectations follow HAZARD_PERF_EN.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [1:0]  pcsource;
  logic [4:0]  d_rs, d_rt, e_rn;
  logic        d_use_rs, d_use_rt, d_md, d_hilo, e_wreg, e_m2reg;
  logic        wpc, wir, flush_ir, bubble, md_start, md_busy, md_done;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.MD_LAT(32)) dut (
    .clk(clk), .clr(clr), .pcsource(pcsource),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_md(d_md), .d_hilo(d_hilo), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn),
    .wpc(wpc), .wir(wir), .flush_ir(flush_ir), .bubble(bubble),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    pcsource = '0; d_rs = '0; d_rt = '0; e_rn = '0;
    d_use_rs = 1'b0; d_use_rt = 1'b0; d_md = 1'b0; d_hilo = 1'b0;
    e_wreg = 1'b0; e_m2reg = 1'b0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic set_load(input logic [4:0] rn);
    e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = rn;
  endtask

  task automatic pulse_reset();
    next(); idle(); clr = 1'b1;
    next(); clr = 1'b0;
  endtask

  initial begin
    idle();
    // reset state
    next(); #1;
    check("rst_wpc", 32'(wpc), 32'd1);
    check("rst_wir", 32'(wir), 32'd1);
    check("rst_flush", 32'(flush_ir), 32'd0);
    check("rst_bubble", 32'(bubble), 32'd0);
    check("rst_start", 32'(md_start), 32'd0);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_done", 32'(md_done), 32'd0);
    check("rst_scnt", stall_cnt, 32'd0);
    check("rst_fcnt", 32'(flush_cnt), 32'd0);
    next(); clr = 1'b0;

    // load-use on rs
    next(); set_load(5'd5); d_rs = 5'd5; d_use_rs = 1'b1; #1;
    check("lu_rs_wpc", 32'(wpc), 32'd0);
    check("lu_rs_wir", 32'(wir), 32'd0);
    check("lu_rs_bub", 32'(bubble), 32'd1);
    next(); idle(); #1;
    check("lu_rel_wpc", 32'(wpc), 32'd1);
    check("lu_rel_bub", 32'(bubble), 32'd0);
    // e_rn = 0 never hazards, even against r0 source
    next(); set_load(5'd0); d_rs = 5'd0; d_use_rs = 1'b1; d_rt = 5'd0; d_use_rt = 1'b1; #1;
    check("lu_r0_bub", 32'(bubble), 32'd0);
    check("lu_r0_wpc", 32'(wpc), 32'd1);
    // load-use on rt, then rt not used, then non-load producer
    next(); idle(); set_load(5'd7); d_rt = 5'd7; d_use_rt = 1'b1; d_rs = 5'd7; #1;
    check("lu_rt_bub", 32'(bubble), 32'd1);
    next(); d_use_rt = 1'b0; #1;
    check("lu_nouse_bub", 32'(bubble), 32'd0);
    next(); d_use_rt = 1'b1; e_m2reg = 1'b0; #1;
    check("lu_noload_bub", 32'(bubble), 32'd0);

    // branch flush, then flush suppressed by load-use
    next(); idle(); pcsource = 2'b01; #1;
    check("br_flush", 32'(flush_ir), 32'd1);
    check("br_wpc", 32'(wpc), 32'd1);
    next(); set_load(5'd9); d_rs = 5'd9; d_use_rs = 1'b1; #1;
    check("br_lu_flush", 32'(flush_ir), 32'd0);
    check("br_lu_wir", 32'(wir), 32'd0);
    next(); idle(); #1;
    check("perf_scnt_a", stall_cnt, PERF ? 32'd3 : 32'd0);
    check("perf_fcnt_a", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);

    // lu and d_md together: no launch until lu clears
    next(); set_load(5'd3); d_rs = 5'd3; d_use_rs = 1'b1; d_md = 1'b1; #1;
    check("lumd_start", 32'(md_start), 32'd0);
    check("lumd_bub", 32'(bubble), 32'd1);
    next(); idle(); d_md = 1'b1; #1;  // cycle T
    check("md_start_T", 32'(md_start), 32'd1);
    check("md_busy_T", 32'(md_busy), 32'd0);
    for (int k = 1; k <= 33; k++) begin
      next(); idle();
      if (k == 5) begin d_hilo = 1'b1; pcsource = 2'b01; end
      #1;
      check("md_busy", 32'(md_busy), (k <= 32) ? 32'd1 : 32'd0);
      check("md_done", 32'(md_done), (k == 32) ? 32'd1 : 32'd0);
      if (k == 5) begin
        check("mh_flush", 32'(flush_ir), 32'd0);
        check("mh_bub", 32'(bubble), 32'd1);
      end
    end

    // back-to-back MD
    pulse_reset();
    next(); idle(); d_md = 1'b1; #1;
    check("b2b_start_T", 32'(md_start), 32'd1);
    for (int k = 1; k <= 33; k++) begin
      next(); #1;
      check("b2b_start", 32'(md_start), (k == 33) ? 32'd1 : 32'd0);
      check("b2b_wir", 32'(wir), (k == 33) ? 32'd1 : 32'd0);
    end
    check("b2b_scnt", stall_cnt, PERF ? 32'd32 : 32'd0);
    for (int k = 1; k <= 33; k++) begin
      next(); idle();
    end
    #1;
    check("b2b_idle_busy", 32'(md_busy), 32'd0);

    // mfhi during busy
    pulse_reset();
    next(); idle(); d_md = 1'b1; #1;
    check("hilo_start", 32'(md_start), 32'd1);
    for (int k = 1; k <= 33; k++) begin
      next(); idle();
      if (k >= 5) d_hilo = 1'b1;
      #1;
      if (k >= 5) check("hilo_wir", 32'(wir), (k == 33) ? 32'd1 : 32'd0);
    end
    check("hilo_busy_end", 32'(md_busy), 32'd0);

    // reset mid-operation
    pulse_reset();
    next(); idle(); d_md = 1'b1; #1;
    check("abort_start", 32'(md_start), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      next(); idle();
    end
    #1;
    check("abort_pre_busy", 32'(md_busy), 32'd1);
    next(); clr = 1'b1; #1;
    check("abort_busy", 32'(md_busy), 32'd0);
    check("abort_done", 32'(md_done), 32'd0);
    check("abort_scnt", stall_cnt, 32'd0);
    check("abort_fcnt", 32'(flush_cnt), 32'd0);
    next(); clr = 1'b0;
    for (int k = 0; k < 25; k++) begin
      next(); #1;
      check("abort_no_done", 32'(md_done), 32'd0);
    end
    check("abort_idle_busy", 32'(md_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
